// File: rtl/disp_mux_scan_if.sv
// Bus bundle for the multiplexed 7-segment scan controller.
// The master drives the display word; the slave returns the scan outputs.
interface disp_mux_scan_if #(
    parameter int N_DIGITS = 4
);
    localparam int IDXW = $clog2(N_DIGITS);

    logic                  load;
    logic [4*N_DIGITS-1:0] hex_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic                  lz_en;
    logic [N_DIGITS-1:0]   an;
    logic [3:0]            hex_out;
    logic                  dp_out;
    logic [IDXW-1:0]       digit_idx;
    logic                  frame_tick;

    modport master (
        output load, hex_in, dp_in, blank_in, lz_en,
        input  an, hex_out, dp_out, digit_idx, frame_tick
    );

    modport slave (
        input  load, hex_in, dp_in, blank_in, lz_en,
        output an, hex_out, dp_out, digit_idx, frame_tick
    );
endinterface

// File: rtl/disp_mux_scan.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Double-buffered word, per-slot guard interval, leading-zero suppression.
module disp_mux_scan #(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_TICKS = 50000,
    parameter int GUARD_TICKS = 500
) (
    input  logic            clk,
    input  logic            reset_n,
    disp_mux_scan_if.slave  bus
);
    localparam int IDXW = $clog2(N_DIGITS);
    localparam int TW   = $clog2(DIGIT_TICKS);
    localparam int NW   = 4 * N_DIGITS;

    typedef enum logic {PH_GUARD, PH_ON} phase_e;

    logic [TW-1:0]       tick_q, tick_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [NW-1:0]       act_hex_q, pend_hex_q;
    logic [N_DIGITS-1:0] act_dp_q, pend_dp_q;
    logic [N_DIGITS-1:0] act_blank_q, pend_blank_q;
    logic                pend_v_q;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [3:0]          hex_q, hex_d;
    logic                dp_q, dp_d;
    logic [IDXW-1:0]     didx_q;
    logic                ft_q, ft_d;

    logic                last_tick, last_idx, commit;
    logic [N_DIGITS-1:0] supp, sel;
    logic                all_zero, cur_dp, cur_dark;
    phase_e              phase;

    always_comb begin
        last_tick = (tick_q == TW'(DIGIT_TICKS - 1));
        last_idx  = (idx_q == IDXW'(N_DIGITS - 1));
        commit    = last_tick & last_idx & pend_v_q;
        tick_d    = last_tick ? '0 : tick_q + 1'b1;
        idx_d     = idx_q;
        if (last_tick) begin
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end
        phase = (int'(tick_q) < GUARD_TICKS) ? PH_GUARD : PH_ON;
    end

    // A digit is suppressed when it and every higher nibble are zero.
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (act_hex_q[4*i +: 4] == 4'h0);
            supp[i]  = bus.lz_en & all_zero & (i != 0);
        end
    end

    always_comb begin
        sel      = '0;
        hex_d    = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                sel[i]   = 1'b1;
                hex_d    = act_hex_q[4*i +: 4];
                cur_dp   = act_dp_q[i];
                cur_dark = act_blank_q[i] | supp[i];
            end
        end
        an_d = '1;
        if (phase == PH_ON && !cur_dark) begin
            an_d = ~sel;
        end
        dp_d = cur_dark | ~cur_dp;
        ft_d = (idx_q == '0) && (tick_q == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            hex_q  <= 4'h0;
            dp_q   <= 1'b1;
            didx_q <= '0;
            ft_q   <= 1'b0;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            hex_q  <= hex_d;
            dp_q   <= dp_d;
            didx_q <= idx_q;
            ft_q   <= ft_d;
        end
    end

    // Load beats the commit clear, so a word landing on the frame edge waits one frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_hex_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_hex_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_v_q     <= 1'b0;
        end else begin
            if (commit) begin
                act_hex_q   <= pend_hex_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= pend_blank_q;
            end
            if (bus.load) begin
                pend_hex_q   <= bus.hex_in;
                pend_dp_q    <= bus.dp_in;
                pend_blank_q <= bus.blank_in;
                pend_v_q     <= 1'b1;
            end else if (commit) begin
                pend_v_q <= 1'b0;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.hex_out    = hex_q;
    assign bus.dp_out     = dp_q;
    assign bus.digit_idx  = didx_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_disp_mux_scan.sv
// Directed bench for disp_mux_scan: vector table plus multi-cycle sequences.
// N_DIGITS=4, DIGIT_TICKS=8, GUARD_TICKS=2 (32-cycle frame).
module tb_disp_mux_scan;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    disp_mux_scan_if #(.N_DIGITS(4)) bus ();

    disp_mux_scan #(
        .N_DIGITS(4), .DIGIT_TICKS(8), .GUARD_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        int          slot;
        int          cyc;
        logic [3:0]  an;
        logic [3:0]  hx;
        logic        dpo;
    } vec_t;

    vec_t tv[21];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepn(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_tick && n < 80);
        if (!bus.frame_tick) begin
            errors++;
            checks++;
            $display("FAIL frame_timeout: got no frame_tick expected one within 80 cycles");
        end
    endtask

    task automatic load_word(input logic [15:0] h, input logic [3:0] d,
                             input logic [3:0] b);
        bus.hex_in   = h;
        bus.dp_in    = d;
        bus.blank_in = b;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        logic [24:0] key, prev;
        logic        have;
        int          n;

        bus.load = 1'b0;
        bus.hex_in = '0;
        bus.dp_in = '0;
        bus.blank_in = '0;
        bus.lz_en = 1'b0;

        tv[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 0, 4'b1111, 4'h4, 1'b1};
        tv[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 1, 4'b1111, 4'h4, 1'b1};
        tv[2]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 2, 4'b1110, 4'h4, 1'b1};
        tv[3]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 7, 4'b1110, 4'h4, 1'b1};
        tv[4]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 1, 3, 4'b1101, 4'h3, 1'b1};
        tv[5]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 2, 5, 4'b1011, 4'h2, 1'b1};
        tv[6]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, 2, 4'b0111, 4'h1, 1'b1};
        tv[7]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 3, 4, 4'b1111, 4'h0, 1'b1};
        tv[8]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 2, 4, 4'b1111, 4'h0, 1'b1};
        tv[9]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 1, 4, 4'b1101, 4'h4, 1'b1};
        tv[10] = '{16'h0040, 4'h0, 4'h0, 1'b1, 0, 4, 4'b1110, 4'h0, 1'b1};
        tv[11] = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 4, 4'b1110, 4'h0, 1'b1};
        tv[12] = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 4, 4'b1111, 4'h0, 1'b1};
        tv[13] = '{16'h0000, 4'h0, 4'h0, 1'b0, 3, 4, 4'b0111, 4'h0, 1'b1};
        tv[14] = '{16'h5678, 4'h2, 4'h4, 1'b0, 2, 4, 4'b1111, 4'h6, 1'b1};
        tv[15] = '{16'h5678, 4'h2, 4'h4, 1'b0, 1, 4, 4'b1101, 4'h7, 1'b0};
        tv[16] = '{16'h5678, 4'h2, 4'h4, 1'b0, 0, 4, 4'b1110, 4'h8, 1'b1};
        tv[17] = '{16'h0100, 4'h0, 4'h4, 1'b1, 1, 4, 4'b1101, 4'h0, 1'b1};
        tv[18] = '{16'h0100, 4'h0, 4'h4, 1'b1, 2, 4, 4'b1111, 4'h1, 1'b1};
        tv[19] = '{16'h0100, 4'h0, 4'h4, 1'b1, 3, 4, 4'b1111, 4'h0, 1'b1};
        tv[20] = '{16'h5678, 4'h2, 4'h2, 1'b0, 1, 4, 4'b1111, 4'h7, 1'b1};

        // Reset hold
        repeat (5) @(posedge clk);
        #1;
        chk("rst_an", bus.an, 4'b1111);
        chk("rst_dp", bus.dp_out, 1'b1);
        chk("rst_hex", bus.hex_out, 4'h0);
        chk("rst_ft", bus.frame_tick, 1'b0);
        chk("rst_idx", bus.digit_idx, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("first_ft", bus.frame_tick, 1'b1);
        chk("first_an", bus.an, 4'b1111);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame_tick && n < 100);
        chk("frame_period", n, 32);

        // Vector table
        have = 1'b0;
        prev = '0;
        for (int i = 0; i < 21; i++) begin
            key = {tv[i].hex, tv[i].dp, tv[i].blank, tv[i].lz};
            if (!have || key != prev) begin
                bus.lz_en = tv[i].lz;
                load_word(tv[i].hex, tv[i].dp, tv[i].blank);
                wait_frame();
                have = 1'b1;
                prev = key;
            end
            wait_frame();
            stepn(tv[i].slot * 8 + tv[i].cyc);
            chk($sformatf("v%0d_an", i), bus.an, tv[i].an);
            chk($sformatf("v%0d_hex", i), bus.hex_out, tv[i].hx);
            chk($sformatf("v%0d_dp", i), bus.dp_out, tv[i].dpo);
            chk($sformatf("v%0d_idx", i), bus.digit_idx, tv[i].slot);
        end

        // Anti-tear: mid-frame load must not show until the next frame
        bus.lz_en = 1'b0;
        load_word(16'h1234, 4'h0, 4'h0);
        wait_frame();
        wait_frame();
        stepn(11);
        load_word(16'hAAAA, 4'h0, 4'h0);
        stepn(16);
        chk("tear_old_hex", bus.hex_out, 4'h1);
        chk("tear_old_an", bus.an, 4'b0111);
        wait_frame();
        chk("tear_new_c0", bus.hex_out, 4'hA);
        stepn(4);
        chk("tear_new_an0", bus.an, 4'b1110);
        chk("tear_new_hex0", bus.hex_out, 4'hA);
        stepn(16);
        chk("tear_new_hex2", bus.hex_out, 4'hA);
        chk("tear_new_an2", bus.an, 4'b1011);

        // Load in the commit cycle: old pending wins, new one waits a frame
        wait_frame();
        load_word(16'h1111, 4'h0, 4'h0);
        stepn(29);
        load_word(16'h2222, 4'h0, 4'h0);
        step();
        chk("cc_ft", bus.frame_tick, 1'b1);
        chk("cc_old_hex", bus.hex_out, 4'h1);
        stepn(28);
        chk("cc_old_hex3", bus.hex_out, 4'h1);
        stepn(8);
        chk("cc_new_hex", bus.hex_out, 4'h2);
        chk("cc_new_an", bus.an, 4'b1110);

        // Asynchronous reset mid-slot 2 drops the pending word
        load_word(16'h3333, 4'h0, 4'h0);
        stepn(14);
        chk("pre_rst_idx", bus.digit_idx, 2'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_an", bus.an, 4'b1111);
        chk("arst_hex", bus.hex_out, 4'h0);
        chk("arst_dp", bus.dp_out, 1'b1);
        chk("arst_idx", bus.digit_idx, 2'd0);
        chk("arst_ft", bus.frame_tick, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rel_ft", bus.frame_tick, 1'b1);
        stepn(4);
        chk("rel_hex0", bus.hex_out, 4'h0);
        chk("rel_an0", bus.an, 4'b1110);
        wait_frame();
        stepn(28);
        chk("rel_hex3", bus.hex_out, 4'h0);
        chk("rel_an3", bus.an, 4'b0111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
